// File: rtl/edge_history.sv
`default_nettype none
// ============================================================================
// Module      : edge_history
// Description : Records the timestamps and polarities of the most recent
//               input-line transitions in a shift register. Each cycle it
//               presents one elapsed-time value per tap, for one pwl instance
//               per tap. A downstream adder weights the taps by polarity.
//
// Ports       : clk, rst        - clock, synchronous active-high reset
//               time_now        - current emulated time (wraps)
//               edge_valid      - candidate transition present this cycle
//               edge_time       - timestamp of the candidate transition
//               edge_bit        - line level after the candidate transition
//               delta           - per-tap elapsed time, tap k at [k*IN_WIDTH +: IN_WIDTH]
//               tap_valid       - tap k holds a live transition
//               tap_rise        - tap k polarity (1 rising, 0 falling)
//               count           - number of live taps in storage
//               drop            - one-cycle pulse: live transition shifted out
//               overflow        - sticky copy of drop, cleared by rst
//
// Revision    : 1.0 - initial release
// ============================================================================
module edge_history #(
    parameter int   N_TAPS     = 4,
    parameter int   TIME_WIDTH = 24,
    parameter int   IN_WIDTH   = 16,
    parameter int   MAX_DELTA  = 40000,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [TIME_WIDTH-1:0]            time_now,
    input  logic                             edge_valid,
    input  logic [TIME_WIDTH-1:0]            edge_time,
    input  logic                             edge_bit,
    output logic [N_TAPS*IN_WIDTH-1:0]       delta,
    output logic [N_TAPS-1:0]                tap_valid,
    output logic [N_TAPS-1:0]                tap_rise,
    output logic [$clog2(N_TAPS+1)-1:0]      count,
    output logic                             drop,
    output logic                             overflow
);

    localparam int                    c_cnt_w = $clog2(N_TAPS + 1);
    localparam logic [TIME_WIDTH-1:0] c_max   = TIME_WIDTH'(MAX_DELTA);
    localparam logic [TIME_WIDTH-1:0] c_sat   = TIME_WIDTH'((64'd1 << IN_WIDTH) - 64'd1);

    // Slot storage
    logic [TIME_WIDTH-1:0] r_t [N_TAPS];
    logic [N_TAPS-1:0]     r_r;
    logic [N_TAPS-1:0]     r_v;
    logic                  r_level;
    logic [TIME_WIDTH-1:0] r_time_now_q;

    // Combinational per-slot evaluation
    logic [TIME_WIDTH-1:0] w_raw [N_TAPS];
    logic [IN_WIDTH-1:0]   w_dsat [N_TAPS];
    logic [N_TAPS-1:0]     w_exp;
    logic [N_TAPS-1:0]     w_live;
    logic [N_TAPS-1:0]     w_v_next;
    logic [c_cnt_w-1:0]    w_count_next;
    logic                  w_accept;
    logic                  w_drop;

    // A repeated level is not a transition, so it never enters storage.
    assign w_accept = edge_valid & (edge_bit != r_level);

    // Age is a modular difference so it stays correct across counter wrap.
    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            w_raw[k]  = r_time_now_q - r_t[k];
            w_exp[k]  = r_v[k] & (w_raw[k] >= c_max);
            w_live[k] = r_v[k] & ~w_exp[k];
            w_dsat[k] = (w_raw[k] > c_sat) ? {IN_WIDTH{1'b1}} : w_raw[k][IN_WIDTH-1:0];
        end
    end

    // Expiry is applied to the pre-shift contents, so an expiring slot
    // arrives at its shifted position already invalid.
    always_comb begin
        w_v_next = w_live;
        if (w_accept) begin
            for (int k = N_TAPS - 1; k > 0; k--) begin
                w_v_next[k] = w_live[k-1];
            end
            w_v_next[0] = 1'b1;
        end
    end

    assign w_drop = w_accept & w_live[N_TAPS-1];

    always_comb begin
        w_count_next = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            w_count_next = w_count_next + c_cnt_w'(w_v_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                r_t[k] <= '0;
            end
            r_r          <= '0;
            r_v          <= '0;
            r_level      <= INIT_LEVEL;
            r_time_now_q <= '0;
            delta        <= '0;
            tap_valid    <= '0;
            tap_rise     <= '0;
            count        <= '0;
            drop         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            r_time_now_q <= time_now;
            r_v          <= w_v_next;
            count        <= w_count_next;
            drop         <= w_drop;
            if (w_drop) begin
                overflow <= 1'b1;
            end

            if (w_accept) begin
                for (int k = N_TAPS - 1; k > 0; k--) begin
                    r_t[k] <= r_t[k-1];
                    r_r[k] <= r_r[k-1];
                end
                r_t[0]  <= edge_time;
                r_r[0]  <= edge_bit;
                r_level <= edge_bit;
            end

            // Outputs reflect the storage as it stood before this update.
            for (int k = 0; k < N_TAPS; k++) begin
                delta[k*IN_WIDTH +: IN_WIDTH] <= w_live[k] ? w_dsat[k] : '0;
            end
            tap_valid <= w_live;
            tap_rise  <= r_r;
        end
    end

endmodule
`default_nettype wire
